divide_unit_scheduler: RTL and testbench
========================================

// Module: divide_unit_scheduler
// PURPOSE
//  Shares one combinational newton_raphson_divide_16_16 instance between two requesters.
//  Arbitrates requests round-robin, registers operands, and holds them stable for SETTLE cycles
//  (multicycle path through the divider), then captures and returns the quotient.
//  Sits between integer-datapath clients and the divider; it is the only driver of the divider inputs.
// PARAMETERS
//  SETTLE  2   cycles operands are held before the quotient is captured (>=1)
//  W       16  operand/quotient width; fixed by the divider, not retargetable
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset, synchronous and active-high
//  req_valid  in   2   request i presents operands
//  req_ready  out  2   request i accepted this cycle (valid&ready = accept)
//  req_n0     in   16  numerator, requester 0
//  req_d0     in   16  denominator, requester 0
//  req_n1     in   16  numerator, requester 1
//  req_d1     in   16  denominator, requester 1
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   consumer takes response (valid&ready = retire)
//  rsp_id     out  1   index of requester that owns the response
//  rsp_q      out  16  quotient
//  rsp_dz     out  1   denominator was zero; rsp_q = 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_dz=0, rr_last=1 (req0 wins first), cnt=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: grant = round-robin among req_valid; req_ready[grant]=1 only in IDLE, other bit 0.
//    On accept: latch n,d,id; rr_last<=id; if d==0 -> DONE with q=FFFF, dz=1; else cnt<=SETTLE-1, -> BUSY.
//   BUSY: divider inputs (ne,de) driven from latched regs only; cnt decrements; at cnt==0 capture
//    divider out into rsp_q, rsp_dz=0, -> DONE.
//   DONE: rsp_valid=1; rsp_* stable until rsp_ready; on rsp_ready -> IDLE (no accept same cycle).
//  Latency: accept at cycle t -> rsp_valid at t+1+SETTLE (nonzero d); t+1 (d==0).
//  Throughput: one divide per SETTLE+2 cycles when rsp_ready held high.
//  Round-robin: both valid -> grant = ~rr_last; single valid -> that one regardless of rr_last.
//  req_ready is combinational from state, rr_last and req_valid; no path from rsp_ready to req_ready.
//  Requesters may drop valid before accept; no penalty, no state change.
//  Divider inputs held at last latched values in IDLE/DONE (no toggling while idle).
//  rst mid BUSY/DONE: operation discarded, rsp_valid=0 next cycle, no response ever issued for it.
//  rsp_ready while rsp_valid=0: ignored.
// STRUCTURE
//  Shared package: state encoding (IDLE/BUSY/DONE), DIV_W=16, DZ_QUOTIENT=16'hFFFF.
//  One sub-module: newton_raphson_divide_16_16 (ports ne, de, out), instantiated once.
//  Arbiter, FSM and settle counter inline; cnt width = $clog2(SETTLE+1).
// TESTING
//  1. req0 n=18,d=3, rsp_ready=1, SETTLE=2 -> rsp_valid 3 cycles after accept, q=6, id=0, dz=0.
//  2. After reset, both valid (18/3, 100/10) held -> req0 first (q=6,id=0), then req1 (q=10,id=1);
//     repeat with both valid -> order alternates per round-robin.
//  3. req1 n=5,d=0 -> rsp one cycle after accept, q=16'hFFFF, dz=1, id=1.
//  4. rsp_ready low 5 cycles in DONE -> rsp_* stable, req_ready=2'b00, then retire and re-accept.
//  5. rst pulsed during BUSY -> rsp_valid=0 next cycle, no response; next request served normally.
//  6. SETTLE=1 build, req0 65535/255 -> q=257 two cycles after accept.

Source files
------------

// File: rtl/divide_unit_scheduler_pkg.sv
// Shared types and constants for the divide unit scheduler.
package divide_unit_scheduler_pkg;
  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/divide_unit_scheduler_div.sv
// Combinational 16/16 unsigned divider: Newton-Raphson reciprocal of the
// normalised denominator, multiply by the numerator, then exact remainder fix-up.
module newton_raphson_divide_16_16
  import divide_unit_scheduler_pkg::*;
(
  input  logic [DIV_W-1:0] ne,
  input  logic [DIV_W-1:0] de,
  output logic [DIV_W-1:0] out
);
  logic [3:0]  w_lz;
  logic [15:0] w_dn;
  logic [31:0] w_dq;   // normalised denominator, Q0.32 in [0.5,1)
  logic [31:0] w_x;    // reciprocal estimate, Q2.30
  logic [31:0] w_t;
  logic [16:0] w_q;
  logic [33:0] w_r;    // remainder, bit 33 is the sign

  // Reciprocal iteration and quotient correction
  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 16; i++)
      if (de[i]) w_lz = 4'(15 - i);
    w_dn = de << w_lz;
    w_dq = {w_dn, 16'h0000};
    // x0 = 48/17 - 32/17 * D keeps initial relative error below 1/17
    w_x  = 32'd3031741621 - 32'((64'(w_dq) * 64'd2021161081) >> 32);
    w_t  = 32'd0;
    for (int k = 0; k < 3; k++) begin
      w_t = 32'((64'(w_dq) * 64'(w_x)) >> 32);
      w_x = 32'((64'(w_x) * 64'(32'h8000_0000 - w_t)) >> 30);
    end
    // q = ne * 2^lz * x / 2^46; truncation leaves it at most a unit or two off
    w_q = 17'(((64'(ne) * 64'(w_x)) << w_lz) >> 46);
    w_r = 34'(ne) - 34'(w_q) * 34'(de);
    if (w_r[33]) begin
      w_q = w_q - 17'd1;
      w_r = w_r + 34'(de);
    end
    for (int k = 0; k < 2; k++)
      if (!w_r[33] && (w_r >= 34'(de))) begin
        w_q = w_q + 17'd1;
        w_r = w_r - 34'(de);
      end
    out = (de == '0) ? DZ_QUOTIENT : 16'(w_q);
  end
endmodule

// File: rtl/divide_unit_scheduler.sv
// Round-robin scheduler sharing one combinational divider between two clients;
// operands are held SETTLE cycles (multicycle path) before the quotient is captured.
module divide_unit_scheduler
  import divide_unit_scheduler_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [DIV_W-1:0] req_n0,
  input  logic [DIV_W-1:0] req_d0,
  input  logic [DIV_W-1:0] req_n1,
  input  logic [DIV_W-1:0] req_d1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DIV_W-1:0] rsp_q,
  output logic             rsp_dz
);
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_e           r_state, w_next;
  logic             r_rr_last;
  logic [CW-1:0]    r_cnt;
  logic [DIV_W-1:0] r_n, r_d;
  logic             r_id;
  logic             w_grant, w_accept;
  logic [DIV_W-1:0] w_sel_n, w_sel_d, w_quot;

  // Divider only ever sees the latched operands, so it is quiet outside BUSY
  newton_raphson_divide_16_16 u_div (.ne(r_n), .de(r_d), .out(w_quot));

  // Round-robin pick: contested -> the one not served last, else whoever asks
  always_comb begin
    w_grant = 1'b0;
    if (&req_valid)        w_grant = ~r_rr_last;
    else if (req_valid[1]) w_grant = 1'b1;
    w_sel_n = w_grant ? req_n1 : req_n0;
    w_sel_d = w_grant ? req_d1 : req_d0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = (w_sel_d == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; no rsp_ready -> req_ready path
  always_comb begin
    w_accept  = (r_state == ST_IDLE) && (|req_valid);
    req_ready = 2'b00;
    if (w_accept) req_ready = w_grant ? 2'b10 : 2'b01;
    rsp_valid = (r_state == ST_DONE);
  end

  // Operand latch, settle counter, fairness pointer and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_n       <= '0;
      r_d       <= '0;
      r_id      <= 1'b0;
      rsp_q     <= '0;
      rsp_dz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n       <= w_sel_n;
        r_d       <= w_sel_d;
        r_id      <= w_grant;
        r_rr_last <= w_grant;
        r_cnt     <= CW'(SETTLE - 1);
        if (w_sel_d == '0) begin
          rsp_q  <= DZ_QUOTIENT;
          rsp_dz <= 1'b1;
        end
      end
      if (r_state == ST_BUSY) begin
        if (r_cnt == '0) begin
          rsp_q  <= w_quot;
          rsp_dz <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign rsp_id = r_id;
endmodule

// File: tb/tb_divide_unit_scheduler.sv
// Directed bench for divide_unit_scheduler (SETTLE=2 main DUT, SETTLE=1 second DUT).
module tb_divide_unit_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_n0, req_d0, req_n1, req_d1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dz;
  logic [15:0] rsp_q;

  logic [1:0]  v2, rdy2;
  logic [15:0] n2, d2, q2;
  logic        rv2, id2, dz2;
  logic [15:0] zero16 = 16'd0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divide_unit_scheduler #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n0(req_n0), .req_d0(req_d0), .req_n1(req_n1), .req_d1(req_d1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_dz(rsp_dz));

  divide_unit_scheduler #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
    .req_n0(n2), .req_d0(d2), .req_n1(zero16), .req_d1(zero16),
    .rsp_valid(rv2), .rsp_ready(1'b1), .rsp_id(id2),
    .rsp_q(q2), .rsp_dz(dz2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request, wait for its accept, then drop valid
  task automatic send(input int id, input logic [15:0] n, input logic [15:0] d);
    int k = 0;
    if (id == 0) begin req_n0 = n; req_d0 = d; end
    else         begin req_n1 = n; req_d1 = d; end
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && k < 50) begin @(negedge clk); #1; k++; end
    if (k == 50) chk("accept timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  // Count negedges from the one after accept until rsp_valid shows up
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!rsp_valid) chk("rsp timeout", 0, 1);
  endtask

  typedef struct { logic [15:0] n, d, q; } vec_t;
  vec_t vecs[5];

  initial begin
    int lat;
    logic [1:0] exp_g;
    vecs[0] = '{16'd1000,  16'd1,     16'd1000};
    vecs[1] = '{16'd65535, 16'd65535, 16'd1};
    vecs[2] = '{16'd7,     16'd9,     16'd0};
    vecs[3] = '{16'd40000, 16'd3,     16'd13333};
    vecs[4] = '{16'd65535, 16'd256,   16'd255};

    req_valid = 2'b00; req_n0 = 0; req_d0 = 0; req_n1 = 0; req_d1 = 0;
    rsp_ready = 1'b1; v2 = 2'b00; n2 = 0; d2 = 0;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst valid", rsp_valid, 0);
    chk("rst id", rsp_id, 0);
    chk("rst q", rsp_q, 0);
    chk("rst dz", rsp_dz, 0);
    chk("rst ready", req_ready, 2'b00);

    // 1: single divide, latency SETTLE+1
    send(0, 16'd18, 16'd3);
    wait_rsp(lat);
    chk("t1 lat", lat, 3);
    chk("t1 q", rsp_q, 6);
    chk("t1 id", rsp_id, 0);
    chk("t1 dz", rsp_dz, 0);
    @(negedge clk);

    // 2: both valid held -> grants alternate starting with req0
    do_reset();
    req_n0 = 16'd18; req_d0 = 16'd3; req_n1 = 16'd100; req_d1 = 16'd10;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      while (req_ready == 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
      chk("t2 grant", req_ready, exp_g);
      @(posedge clk);
      @(negedge clk);
      wait_rsp(lat);
      chk("t2 id", rsp_id, (i % 2));
      chk("t2 q", rsp_q, (i % 2 == 0) ? 6 : 10);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // 3: divide by zero -> one-cycle response
    send(1, 16'd5, 16'd0);
    wait_rsp(lat);
    chk("t3 lat", lat, 1);
    chk("t3 q", rsp_q, 16'hFFFF);
    chk("t3 dz", rsp_dz, 1);
    chk("t3 id", rsp_id, 1);
    @(negedge clk);

    // extra quotients
    foreach (vecs[i]) begin
      send(0, vecs[i].n, vecs[i].d);
      wait_rsp(lat);
      chk("vec lat", lat, 3);
      chk("vec q", rsp_q, vecs[i].q);
      @(negedge clk);
    end

    // 4: backpressure holds response, blocks new accepts
    rsp_ready = 1'b0;
    send(0, 16'd100, 16'd7);
    wait_rsp(lat);
    req_n1 = 16'd20; req_d1 = 16'd4; req_valid[1] = 1'b1;
    repeat (5) begin
      #1;
      chk("t4 hold", {rsp_valid, rsp_id, rsp_dz, rsp_q, req_ready}, {1'b1, 1'b0, 1'b0, 16'd14, 2'b00});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t4 reaccept rdy", req_ready, 2'b10);
    send(1, 16'd20, 16'd4);
    wait_rsp(lat);
    chk("t4 lat", lat, 3);
    chk("t4 q", {rsp_id, rsp_q}, {1'b1, 16'd5});
    @(negedge clk);

    // 5: reset during BUSY discards the operation
    send(0, 16'd50, 16'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 valid after rst", rsp_valid, 0);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
      chk("t5 no rsp", seen, 0);
    end
    send(1, 16'd81, 16'd9);
    wait_rsp(lat);
    chk("t5 lat", lat, 3);
    chk("t5 q", {rsp_id, rsp_q}, {1'b1, 16'd9});
    @(negedge clk);

    // 6: SETTLE=1 instance
    n2 = 16'd65535; d2 = 16'd255; v2 = 2'b01;
    #1;
    chk("t6 ready", rdy2, 2'b01);
    @(posedge clk);
    @(negedge clk);
    v2 = 2'b00;
    lat = 1;
    while (!rv2 && lat < 40) begin @(negedge clk); lat++; end
    chk("t6 lat", lat, 2);
    chk("t6 q", q2, 16'd257);
    chk("t6 dz", dz2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
